// File: rtl/gcd_job_feeder_pkg.sv
// Shared types for the GCD job feeder: FSM state encoding and default widths.
package gcd_job_feeder_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    LOAD_A    = 3'd1,
    LOAD_B    = 3'd2,
    WAIT_DONE = 3'd3,
    CLEAR     = 3'd4,
    EMIT      = 3'd5
  } state_e;
endpackage

// File: rtl/gcd_job_feeder_pair_fifo.sv
// Operand-pair FIFO; the occupancy counter carries one extra bit so full and empty are unambiguous.
module gcd_pair_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/gcd_job_feeder.sv
// Feeds buffered (A,B) pairs to a subtractive GCD core over its shared load bus and returns results.
module gcd_job_feeder
  import gcd_job_feeder_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = 4,
  parameter int MAX_CYC = 1023,
  parameter int CW      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             start,
  output logic [WIDTH-1:0] data_in,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             core_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic [CW-1:0]    out_cycles
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               start_q, start_d, clr_q, clr_d, ov_q, ov_d, err_q, err_d;
  logic [WIDTH-1:0]   din_q, din_d, gcd_q, gcd_d;
  logic [CW-1:0]      cyc_q, cyc_d;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [2*WIDTH-1:0] fifo_dout;
  logic [WIDTH-1:0]   head_a, head_b;

  gcd_pair_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .din   ({in_a, in_b}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_a   = fifo_dout[2*WIDTH-1:WIDTH];
  assign head_b   = fifo_dout[WIDTH-1:0];
  assign in_ready = !fifo_full;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    din_d    = din_q;
    clr_d    = clr_q;
    ov_d     = ov_q;
    gcd_d    = gcd_q;
    err_d    = err_q;
    cyc_d    = cyc_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        // A zero operand would spin the subtractive core forever, so answer directly.
        if (head_a == '0 || head_b == '0) begin
          gcd_d   = head_a | head_b;
          err_d   = 1'b0;
          cyc_d   = '0;
          ov_d    = 1'b1;
          state_d = EMIT;
        end else begin
          a_d     = head_a;
          b_d     = head_b;
          start_d = 1'b1;
          din_d   = head_a;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        start_d = 1'b0;
        din_d   = b_q;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (core_done) begin
          gcd_d   = core_result;
          err_d   = 1'b0;
          cyc_d   = cnt_q;
          clr_d   = 1'b1;
          state_d = CLEAR;
        end else if (cnt_q == CW'(MAX_CYC)) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          cyc_d   = cnt_q;
          clr_d   = 1'b1;
          state_d = CLEAR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CLEAR: begin
        clr_d   = 1'b0;
        ov_d    = 1'b1;
        state_d = EMIT;
      end
      EMIT: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      din_q   <= '0;
      clr_q   <= 1'b0;
      ov_q    <= 1'b0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      din_q   <= din_d;
      clr_q   <= clr_d;
      ov_q    <= ov_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  assign start      = start_q;
  assign data_in    = din_q;
  assign core_clr   = clr_q;
  assign out_valid  = ov_q;
  assign out_gcd    = gcd_q;
  assign out_err    = err_q;
  assign out_cycles = cyc_q;
endmodule

// File: tb/tb_gcd_job_feeder.sv
// Scoreboard bench for gcd_job_feeder with a behavioural GCD core stub.
module tb_gcd_job_feeder;
  localparam int W = 16;
  localparam int CW = 10;
  localparam int LAT = 2;

  typedef struct {
    logic [W-1:0]  g;
    logic          e;
    logic [CW-1:0] c;
  } exp_t;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, start, core_done, core_clr, out_valid, out_ready = 1, out_err;
  logic [W-1:0] in_a = 0, in_b = 0, data_in, core_result, out_gcd;
  logic [CW-1:0] out_cycles;

  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int clr_cnt = 0, start_cnt = 0;
  bit hang = 0;

  gcd_job_feeder #(.WIDTH(W), .DEPTH(4), .MAX_CYC(1023), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .start(start), .data_in(data_in), .core_done(core_done), .core_result(core_result),
    .core_clr(core_clr), .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_err(out_err), .out_cycles(out_cycles)
  );

  always #5 clk = ~clk;

  // Core stub: latch A on start, B next cycle, raise done LAT+1 cycles later, hold until clr.
  logic [1:0] ph;
  logic [W-1:0] sa, sb;
  int w;
  logic done_r;
  logic [W-1:0] res_r;
  assign core_done = done_r;
  assign core_result = res_r;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a, y = b, t;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0; done_r <= 0; res_r <= 0; w <= 0; sa <= 0; sb <= 0;
    end else if (core_clr) begin
      ph <= 0; done_r <= 0;
    end else begin
      case (ph)
        2'd0: if (start) begin sa <= data_in; ph <= 2'd1; end
        2'd1: begin sb <= data_in; w <= 0; ph <= 2'd2; end
        2'd2: if (!hang) begin
          if (w == LAT) begin done_r <= 1; res_r <= gcd_f(sa, sb); ph <= 2'd3; end
          else w <= w + 1;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (core_clr) clr_cnt++;
    if (start) start_cnt++;
  end

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got gcd %0d with no expected entry", out_gcd);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("out_gcd", 32'(out_gcd), 32'(x.g));
        chk("out_err", 32'(out_err), 32'(x.e));
        chk("out_cycles", 32'(out_cycles), 32'(x.c));
      end
    end
  end

  // Drive at posedge+1; accepted on the next edge where in_ready is high.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g,
                      input logic e, input logic [CW-1:0] c, input int budget, output bit ok);
    ok = 0;
    in_valid = 1; in_a = a; in_b = b;
    for (int t = 0; t < budget; t++) begin
      if (in_ready) begin
        exp_t x;
        x.g = g; x.e = e; x.c = c;
        @(posedge clk);
        exp_q.push_back(x);
        #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic push_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g,
                          input logic e, input logic [CW-1:0] c);
    bit ok;
    push(a, b, g, e, c, 200, ok);
    chk("push_accepted", 32'(ok), 1);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_data_in"}, 32'(data_in), 0);
    chk({tag, "_core_clr"}, 32'(core_clr), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_gcd"}, 32'(out_gcd), 0);
    chk({tag, "_out_err"}, 32'(out_err), 0);
    chk({tag, "_out_cycles"}, 32'(out_cycles), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    int c0, s0, seen;
    bit ok;
    #2;
    chk_idle_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // 1: basic job through the core stub
    c0 = clr_cnt; s0 = start_cnt;
    push_req(48, 18, 6, 0, 3);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = start; end
    chk("t1_start_seen", 32'(seen), 1);
    chk("t1_data_in_a", 32'(data_in), 48);
    @(negedge clk);
    chk("t1_start_pulse_end", 32'(start), 0);
    chk("t1_data_in_b", 32'(data_in), 18);
    drain(100);
    chk("t1_clr_pulses", 32'(clr_cnt - c0), 1);
    chk("t1_start_pulses", 32'(start_cnt - s0), 1);

    // 2: zero-operand bypass
    s0 = start_cnt; c0 = clr_cnt;
    push_req(0, 7, 7, 0, 0);
    push_req(0, 0, 0, 0, 0);
    drain(100);
    chk("t2_no_start", 32'(start_cnt - s0), 0);
    chk("t2_no_clr", 32'(clr_cnt - c0), 0);

    // 3: fill FIFO behind a stalled job, then drain in order
    out_ready = 0;
    push_req(12, 8, 4, 0, 3);
    push_req(17, 5, 1, 0, 3);
    push_req(100, 75, 25, 0, 3);
    push_req(21, 14, 7, 0, 3);
    push_req(9, 27, 9, 0, 3);
    repeat (15) @(posedge clk);
    #1;
    chk("t3_in_ready_full", 32'(in_ready), 0);
    chk("t3_out_valid_held", 32'(out_valid), 1);
    push(35, 49, 7, 0, 3, 5, ok);
    chk("t3_sixth_stalled", 32'(ok), 0);
    out_ready = 1;
    push(35, 49, 7, 0, 3, 200, ok);
    chk("t3_sixth_accepted", 32'(ok), 1);
    drain(400);

    // 4: core never finishes -> timeout
    hang = 1; c0 = clr_cnt;
    push_req(5, 3, 0, 1, 1023);
    drain(1300);
    hang = 0;
    chk("t4_clr_pulses", 32'(clr_cnt - c0), 1);

    // 5: reset in the middle of WAIT_DONE with two pairs queued
    hang = 1;
    push_req(6, 4, 2, 0, 3);
    push_req(9, 3, 3, 0, 3);
    push_req(2, 8, 2, 0, 3);
    repeat (15) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk_idle_outputs("t5_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0; hang = 0;
    s0 = start_cnt; seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid) seen = 1; end
    chk("t5_no_output_after_rst", 32'(seen), 0);
    chk("t5_no_start_after_rst", 32'(start_cnt - s0), 0);
    @(posedge clk); #1;
    push_req(8, 12, 4, 0, 3);
    drain(100);

    // 6: consumer stalls for 10 cycles in EMIT
    out_ready = 0;
    push_req(20, 30, 10, 0, 3);
    push_req(7, 21, 7, 0, 3);
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin @(negedge clk); seen = out_valid; end
    chk("t6_out_valid_seen", 32'(seen), 1);
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", 32'(out_valid), 1);
      chk("t6_hold_gcd", 32'(out_gcd), 10);
      chk("t6_hold_err", 32'(out_err), 0);
      chk("t6_hold_cycles", 32'(out_cycles), 3);
    end
    chk("t6_no_pop_before_handshake", 32'(start_cnt - s0), 0);
    @(posedge clk); #1;
    out_ready = 1;
    drain(200);
    chk("t6_second_job_started", 32'(start_cnt - s0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
